sprite_plotter: RTL and testbench
=================================

Name: sprite_plotter

Overview:
- Downstream of the animation datapath: converts one object position (x, y) plus a draw/erase request into a serial stream of single-pixel writes for the VGA adapter.
- Walks a W×H sprite bitmap row-major and emits one pixel per clock.
- Clips against screen bounds.
- Reports busy/done so the control FSM can sequence its erase→draw steps.

Parameters:
- SPRITE_W, 8, sprite width in pixels (1..16)
- SPRITE_H, 8, sprite height in pixels (1..16)
- SCREEN_W, 160, visible columns; pixels with x ≥ SCREEN_W are clipped
- SCREEN_H, 120, visible rows; pixels with y ≥ SCREEN_H are clipped
- MASK, all ones, SPRITE_W*SPRITE_H bits; bit (cy*SPRITE_W+cx) = 1 means the pixel belongs to the sprite
- BG_COLOUR, 3'b000, colour written in erase mode

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high; clock is clk
- start  in  1  request a plot pass; accepted only when busy=0
- erase  in  1  sampled with start: 1 = write BG_COLOUR, 0 = write colour
- x_in  in  8  sprite top-left column, sampled with start
- y_in  in  7  sprite top-left row, sampled with start
- colour  in  3  foreground colour, sampled with start
- busy  out  1  pass in progress; start ignored while high
- done  out  1  one-cycle pulse at end of pass
- vga_x  out  8  pixel column to adapter
- vga_y  out  7  pixel row to adapter
- vga_colour  out  3  pixel colour to adapter
- vga_plot  out  1  write strobe to adapter

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0; counters and latches cleared.
- All outputs are registered. N = SPRITE_W*SPRITE_H.
- FSM states: IDLE, DRAW, FIN.
- IDLE:
  - start=1 at edge E0 → latch x_in, y_in, erase, colour.
  - Set cx=0, cy=0, busy<=1, go to DRAW.
  - start=0 → stay; outputs hold with vga_plot=0.
- DRAW, one pixel per edge:
  - Register vga_x = x0+cx and vga_y = y0+cy (low bits).
  - Register vga_colour = erase ? BG_COLOUR : colour.
  - vga_plot = MASK[cy*W+cx] AND (x0+cx < SCREEN_W) AND (y0+cy < SCREEN_H).
  - Sums computed at 9 bits (x) / 8 bits (y) before comparing, so there is no wrap to column 0.
  - Advance cx; on cx=W-1, cx←0 and cy++.
  - The edge that registers pixel N-1 moves the FSM to FIN.
- FIN: at the next edge, vga_plot<=0, done<=1, state→IDLE. On the following edge, done<=0 and busy<=0.
- Timing, start sampled in cycle C0:
  - busy high C1..C(N+2).
  - Pixel k is on the outputs in cycle C(k+2), for k=0..N-1.
  - done=1 only in C(N+2), with vga_plot=0.
  - Earliest next accepted start is C(N+3).
- Masked or clipped slots still consume a cycle and update vga_x/vga_y; only vga_plot is 0.
- start while busy=1: ignored. A pending start is not queued. Latched parameters are not changed.
- Input changes on x_in/y_in/erase/colour during a pass do not affect that pass.
- start held high continuously: a new pass begins each time busy is 0 at an edge.
- Reset mid-pass: immediate abort. vga_plot=0, no done pulse, state IDLE.
- Erase and draw use the same mask and clipping, so an erase pass exactly removes a prior draw pass at the same position.

Test Plan:
- W=H=4, MASK all 1; start with x_in=10, y_in=20, colour=3'b100, erase=0 at C0 → vga_plot=1 in C2..C17 with (x,y) = (10,20),(11,20)…(13,20),(10,21)…(13,23), colour 100; done=1 only in C18; busy C1..C18.
- Same position with erase=1 → identical coordinate sequence, vga_colour=000 throughout, done in C18.
- Clipping: x_in=158, y_in=118, W=H=4 → plots only at x∈{158,159}, y∈{118,119} (4 strobes); the other 12 slots have vga_plot=0; no pixel at x=0..1; done still in C18.
- MASK=16'h8421 (diagonal), x_in=0, y_in=0 → vga_plot=1 only at (0,0),(1,1),(2,2),(3,3), i.e. cycles C2, C7, C12, C17.
- start pulsed in C5 during a pass, and x_in changed mid-pass → no effect on the sequence; exactly one done, in C18; a new start in C19 begins a fresh pass with busy from C20.
- reset asserted asynchronously in C8 → busy, vga_plot and done drop immediately; no done pulse follows; a start after reset release runs a full 16-pixel pass.

Source files
------------

// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - serialises a masked, screen-clipped sprite into single-pixel VGA writes
module sprite_plotter #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter logic [SPRITE_W*SPRITE_H-1:0] MASK = '1,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       erase,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam int N = SPRITE_W * SPRITE_H;

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t       state_q;
    logic [7:0]   x0_q;
    logic [6:0]   y0_q;
    logic         erase_q;
    logic [2:0]   colour_q;
    logic [4:0]   cx_q;
    logic [4:0]   cy_q;
    logic [N-1:0] mask_q;
    logic         busy_q;
    logic         done_q;
    logic         plot_q;
    logic [7:0]   vx_q;
    logic [6:0]   vy_q;
    logic [2:0]   vc_q;

    logic [8:0]   x_sum;
    logic [7:0]   y_sum;
    logic         in_bounds;
    logic         last_pix;

    // One extra bit on the sums so sprites hanging off the right/bottom clip instead of wrapping
    assign x_sum     = {1'b0, x0_q} + {4'b0000, cx_q};
    assign y_sum     = {1'b0, y0_q} + {3'b000, cy_q};
    assign in_bounds = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));
    assign last_pix  = (cx_q == 5'(SPRITE_W - 1)) && (cy_q == 5'(SPRITE_H - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            erase_q  <= 1'b0;
            colour_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            mask_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            vx_q     <= '0;
            vy_q     <= '0;
            vc_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    plot_q <= 1'b0;
                    done_q <= 1'b0;
                    // busy still high here means the pass just finished; starts wait one more edge
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (start) begin
                        x0_q     <= x_in;
                        y0_q     <= y_in;
                        erase_q  <= erase;
                        colour_q <= colour;
                        cx_q     <= '0;
                        cy_q     <= '0;
                        mask_q   <= MASK;
                        busy_q   <= 1'b1;
                        state_q  <= DRAW;
                    end
                end
                DRAW: begin
                    vx_q   <= x_sum[7:0];
                    vy_q   <= y_sum[6:0];
                    vc_q   <= erase_q ? BG_COLOUR : colour_q;
                    plot_q <= mask_q[0] && in_bounds;
                    mask_q <= mask_q >> 1;
                    if (cx_q == 5'(SPRITE_W - 1)) begin
                        cx_q <= '0;
                        cy_q <= cy_q + 5'd1;
                    end else begin
                        cx_q <= cx_q + 5'd1;
                    end
                    if (last_pix) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    plot_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;
    assign vga_plot   = plot_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - directed vector bench for sprite_plotter with a 4x4 sprite
module tb_sprite_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       erase;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour;

    logic       busy_a, done_a, plot_a;
    logic [7:0] vx_a;
    logic [6:0] vy_a;
    logic [2:0] vc_a;
    logic       busy_d, done_d, plot_d;
    logic [7:0] vx_d;
    logic [6:0] vy_d;
    logic [2:0] vc_d;

    logic       s_busy, s_done, s_plot;
    logic [7:0] s_x;
    logic [6:0] s_y;
    logic [2:0] s_c;
    logic       use_diag;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sprite_plotter #(.SPRITE_W(4), .SPRITE_H(4), .MASK(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .start(start), .erase(erase),
        .x_in(x_in), .y_in(y_in), .colour(colour),
        .busy(busy_a), .done(done_a), .vga_x(vx_a), .vga_y(vy_a),
        .vga_colour(vc_a), .vga_plot(plot_a)
    );

    sprite_plotter #(.SPRITE_W(4), .SPRITE_H(4), .MASK(16'h8421)) dut_diag (
        .clk(clk), .reset(reset), .start(start), .erase(erase),
        .x_in(x_in), .y_in(y_in), .colour(colour),
        .busy(busy_d), .done(done_d), .vga_x(vx_d), .vga_y(vy_d),
        .vga_colour(vc_d), .vga_plot(plot_d)
    );

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       er;
        logic       diag;
        int         strobes;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic sample();
        s_busy = use_diag ? busy_d : busy_a;
        s_done = use_diag ? done_d : done_a;
        s_plot = use_diag ? plot_d : plot_a;
        s_x    = use_diag ? vx_d   : vx_a;
        s_y    = use_diag ? vy_d   : vy_a;
        s_c    = use_diag ? vc_d   : vc_a;
    endtask

    // Called at a sample point: the current cycle is C0. Leaves the bench at the sample point of C19.
    task automatic run_pass(input vec_t v, input int disturb, input string tag);
        logic [15:0] m;
        int strobes;
        int k, ex, ey;
        m        = v.diag ? 16'h8421 : 16'hFFFF;
        strobes  = 0;
        use_diag = v.diag;
        x_in   = v.x;
        y_in   = v.y;
        colour = v.col;
        erase  = v.er;
        start  = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (disturb != 0 && c == disturb) begin
                start  = 1'b1;
                x_in   = 8'd50;
                y_in   = 7'd3;
                colour = ~v.col;
                erase  = ~v.er;
            end
            sample();
            chk($sformatf("%s busy C%0d", tag, c), int'(s_busy), (c <= 18) ? 1 : 0);
            chk($sformatf("%s done C%0d", tag, c), int'(s_done), (c == 18) ? 1 : 0);
            if (c >= 2 && c <= 17) begin
                k  = c - 2;
                ex = int'(v.x) + k % 4;
                ey = int'(v.y) + k / 4;
                chk($sformatf("%s x C%0d", tag, c), int'(s_x), ex % 256);
                chk($sformatf("%s y C%0d", tag, c), int'(s_y), ey % 128);
                chk($sformatf("%s colour C%0d", tag, c), int'(s_c), v.er ? 0 : int'(v.col));
                chk($sformatf("%s plot C%0d", tag, c), int'(s_plot),
                    (m[k] && ex < 160 && ey < 120) ? 1 : 0);
                if (s_plot) strobes++;
            end else begin
                chk($sformatf("%s plot C%0d", tag, c), int'(s_plot), 0);
            end
        end
        chk($sformatf("%s strobes", tag), strobes, v.strobes);
    endtask

    initial begin
        vec_t v;
        int   seen_done;

        vecs[0] = '{x: 8'd10,  y: 7'd20,  col: 3'b100, er: 1'b0, diag: 1'b0, strobes: 16};
        vecs[1] = '{x: 8'd10,  y: 7'd20,  col: 3'b100, er: 1'b1, diag: 1'b0, strobes: 16};
        vecs[2] = '{x: 8'd158, y: 7'd118, col: 3'b011, er: 1'b0, diag: 1'b0, strobes: 4};
        vecs[3] = '{x: 8'd0,   y: 7'd0,   col: 3'b111, er: 1'b0, diag: 1'b1, strobes: 4};
        vecs[4] = '{x: 8'd156, y: 7'd116, col: 3'b010, er: 1'b0, diag: 1'b0, strobes: 16};
        vecs[5] = '{x: 8'd157, y: 7'd117, col: 3'b001, er: 1'b0, diag: 1'b0, strobes: 9};
        vecs[6] = '{x: 8'd255, y: 7'd127, col: 3'b101, er: 1'b0, diag: 1'b0, strobes: 0};

        reset    = 1'b1;
        start    = 1'b0;
        erase    = 1'b0;
        x_in     = '0;
        y_in     = '0;
        colour   = '0;
        use_diag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sample();
        chk("reset busy", int'(s_busy), 0);
        chk("reset done", int'(s_done), 0);
        chk("reset plot", int'(s_plot), 0);
        chk("reset x", int'(s_x), 0);
        chk("reset y", int'(s_y), 0);
        chk("reset colour", int'(s_c), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        sample();
        chk("idle plot", int'(s_plot), 0);

        // Back-to-back passes: each new start lands in C19 of the previous pass
        for (int i = 0; i < 7; i++) begin
            run_pass(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Start pulse and input changes in C5 must not disturb the running pass
        run_pass(vecs[0], 5, "midstart");
        run_pass(vecs[2], 0, "after_mid");

        // Asynchronous reset in C8 aborts immediately
        use_diag = 1'b0;
        x_in   = 8'd10;
        y_in   = 7'd20;
        colour = 3'b100;
        erase  = 1'b0;
        start  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        sample();
        chk("pre_reset busy", int'(s_busy), 1);
        chk("pre_reset plot", int'(s_plot), 1);
        #2;
        reset = 1'b1;
        #1;
        sample();
        chk("abort busy", int'(s_busy), 0);
        chk("abort plot", int'(s_plot), 0);
        chk("abort done", int'(s_done), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            sample();
            if (s_done || s_busy || s_plot) seen_done++;
        end
        chk("abort quiet", seen_done, 0);

        v = vecs[0];
        run_pass(v, 0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
